// File: rtl/vga_game_pkg.sv
// Shared types and helpers for the VGA text/game display path.
// The fill master uses the state enum and the glyph-word builder.
package vga_game_pkg;

  typedef enum logic [1:0] {
    FILL_IDLE,
    FILL_WAIT_VS,
    FILL_WRITE,
    FILL_DONE
  } fill_state_t;

  localparam int VRAM_WORDS_DEF = 600;
  localparam int CHAR_CODE_W    = 7;

  // Two glyphs per word: low char code at [14:8], high char code at [30:24]
  function automatic logic [31:0] fill_word(input logic [31:0]            pattern,
                                            input logic [CHAR_CODE_W-1:0] code,
                                            input logic                   inc);
    logic [CHAR_CODE_W-1:0] code_hi;
    code_hi = code + CHAR_CODE_W'(1);
    if (inc) begin
      fill_word = {pattern[31], code_hi, pattern[23:15], code, pattern[7:0]};
    end else begin
      fill_word = pattern;
    end
  endfunction

endpackage

// File: rtl/vram_fill_master_vs_edge_det.sv
// Registers vsync and flags the cycle in which a 1->0 transition is seen.
module vs_edge_det (
  input  logic CLK,
  input  logic RESET_N,
  input  logic vs,
  output logic vs_fall
);

  logic vs_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      vs_q <= 1'b0;
    end else begin
      vs_q <= vs;
    end
  end

  assign vs_fall = vs_q & ~vs;

endmodule

// File: rtl/vram_fill_master.sv
// Avalon-MM write master that fills a clamped word range of text VRAM,
// optionally starting on a vsync falling edge so a frame is never torn.
module vram_fill_master
  import vga_game_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int VRAM_WORDS = VRAM_WORDS_DEF,
  parameter bit SYNC_TO_VS = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [10:0]       cmd_count,
  input  logic [31:0]       cmd_pattern,
  input  logic              cmd_inc,
  input  logic              vs,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              err,
  output logic              AVL_M_CS,
  output logic              AVL_M_WRITE,
  output logic [ADDR_W-1:0] AVL_M_ADDR,
  output logic [3:0]        AVL_M_BYTE_EN,
  output logic [31:0]       AVL_M_WRITEDATA,
  input  logic              AVL_M_WAITREQ
);

  localparam int                CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  VRAM_LIM = CNT_W'(VRAM_WORDS);

  fill_state_t             state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [31:0]             data_q, data_d;
  logic                    write_q, write_d;
  logic [3:0]              be_q, be_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    aborted_q, aborted_d;
  logic                    err_q, err_d;
  logic [CNT_W-1:0]        remain_q, remain_d;
  logic [CHAR_CODE_W-1:0]  code_q, code_d;
  logic [31:0]             pat_q, pat_d;
  logic                    inc_q, inc_d;
  logic                    abort_pend_q, abort_pend_d;

  logic                    vs_fall;
  logic [CNT_W-1:0]        base_ext, count_ext, room, eff_count;
  logic                    base_bad;

  vs_edge_det u_vs_edge_det (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .vs      (vs),
    .vs_fall (vs_fall)
  );

  // Clamp so the last written address never exceeds VRAM_WORDS-1
  always_comb begin
    base_ext  = {1'b0, cmd_base};
    count_ext = CNT_W'(cmd_count);
    base_bad  = (base_ext >= VRAM_LIM);
    room      = VRAM_LIM - base_ext;
    eff_count = (count_ext < room) ? count_ext : room;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= FILL_IDLE;
      addr_q       <= '0;
      data_q       <= '0;
      write_q      <= 1'b0;
      be_q         <= 4'h0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      err_q        <= 1'b0;
      remain_q     <= '0;
      code_q       <= '0;
      pat_q        <= '0;
      inc_q        <= 1'b0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      write_q      <= write_d;
      be_q         <= be_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      err_q        <= err_d;
      remain_q     <= remain_d;
      code_q       <= code_d;
      pat_q        <= pat_d;
      inc_q        <= inc_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    write_d      = write_q;
    be_d         = be_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    aborted_d    = aborted_q;
    err_d        = err_q;
    remain_d     = remain_q;
    code_d       = code_q;
    pat_d        = pat_q;
    inc_d        = inc_q;
    abort_pend_d = abort_pend_q;

    case (state_q)
      FILL_IDLE: begin
        if (start) begin
          busy_d       = 1'b1;
          aborted_d    = 1'b0;
          err_d        = 1'b0;
          abort_pend_d = 1'b0;
          pat_d        = cmd_pattern;
          inc_d        = cmd_inc;
          code_d       = cmd_pattern[14:8];
          addr_d       = cmd_base;
          remain_d     = eff_count;
          if (base_bad) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = FILL_DONE;
          end else if (eff_count == '0) begin
            done_d  = 1'b1;
            state_d = FILL_DONE;
          end else if (SYNC_TO_VS) begin
            state_d = FILL_WAIT_VS;
          end else begin
            write_d = 1'b1;
            be_d    = 4'hF;
            data_d  = fill_word(cmd_pattern, cmd_pattern[14:8], cmd_inc);
            state_d = FILL_WRITE;
          end
        end
      end

      FILL_WAIT_VS: begin
        if (abort) begin
          aborted_d = 1'b1;
          done_d    = 1'b1;
          state_d   = FILL_DONE;
        end else if (vs_fall) begin
          write_d = 1'b1;
          be_d    = 4'hF;
          data_d  = fill_word(pat_q, code_q, inc_q);
          state_d = FILL_WRITE;
        end
      end

      // An abort is remembered so the stalled word still completes first
      FILL_WRITE: begin
        if (abort) begin
          abort_pend_d = 1'b1;
        end
        if (!AVL_M_WAITREQ) begin
          if ((remain_q == CNT_W'(1)) || abort || abort_pend_q) begin
            write_d   = 1'b0;
            be_d      = 4'h0;
            done_d    = 1'b1;
            aborted_d = abort | abort_pend_q;
            state_d   = FILL_DONE;
          end else begin
            addr_d   = addr_q + ADDR_W'(1);
            remain_d = remain_q - CNT_W'(1);
            code_d   = code_q + CHAR_CODE_W'(2);
            data_d   = fill_word(pat_q, code_q + CHAR_CODE_W'(2), inc_q);
          end
        end
      end

      FILL_DONE: begin
        busy_d  = 1'b0;
        state_d = FILL_IDLE;
      end
    endcase
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign aborted         = aborted_q;
  assign err             = err_q;
  assign AVL_M_CS        = write_q;
  assign AVL_M_WRITE     = write_q;
  assign AVL_M_ADDR      = addr_q;
  assign AVL_M_BYTE_EN   = be_q;
  assign AVL_M_WRITEDATA = data_q;

endmodule

// File: tb/tb_vram_fill_master.sv
// Bench for vram_fill_master: one immediate-start and one vsync-synchronised
// instance, directed scenarios plus randomized fills against a word-level model.
module tb_vram_fill_master;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        start_imm = 1'b0, start_vs = 1'b0, abort = 1'b0;
  logic [11:0] cmd_base = '0;
  logic [10:0] cmd_count = '0;
  logic [31:0] cmd_pattern = '0;
  logic        cmd_inc = 1'b0, vs = 1'b1, waitreq = 1'b0;

  logic        busy_i, done_i, aborted_i, err_i, cs_i, wr_i;
  logic [11:0] addr_i;
  logic [3:0]  be_i;
  logic [31:0] wd_i;
  logic        busy_v, done_v, aborted_v, err_v, cs_v, wr_v;
  logic [11:0] addr_v;
  logic [3:0]  be_v;
  logic [31:0] wd_v;

  logic [43:0] acc_imm[$];
  logic [43:0] acc_vs[$];
  int tests_run = 0;
  int tests_failed = 0;

  always #10 CLK = ~CLK;

  vram_fill_master #(.ADDR_W(12), .VRAM_WORDS(600), .SYNC_TO_VS(1'b0)) u_imm (
    .CLK(CLK), .RESET_N(RESET_N), .start(start_imm), .abort(abort),
    .cmd_base(cmd_base), .cmd_count(cmd_count), .cmd_pattern(cmd_pattern),
    .cmd_inc(cmd_inc), .vs(vs), .busy(busy_i), .done(done_i), .aborted(aborted_i),
    .err(err_i), .AVL_M_CS(cs_i), .AVL_M_WRITE(wr_i), .AVL_M_ADDR(addr_i),
    .AVL_M_BYTE_EN(be_i), .AVL_M_WRITEDATA(wd_i), .AVL_M_WAITREQ(waitreq));

  vram_fill_master #(.ADDR_W(12), .VRAM_WORDS(600), .SYNC_TO_VS(1'b1)) u_vs (
    .CLK(CLK), .RESET_N(RESET_N), .start(start_vs), .abort(abort),
    .cmd_base(cmd_base), .cmd_count(cmd_count), .cmd_pattern(cmd_pattern),
    .cmd_inc(cmd_inc), .vs(vs), .busy(busy_v), .done(done_v), .aborted(aborted_v),
    .err(err_v), .AVL_M_CS(cs_v), .AVL_M_WRITE(wr_v), .AVL_M_ADDR(addr_v),
    .AVL_M_BYTE_EN(be_v), .AVL_M_WRITEDATA(wd_v), .AVL_M_WAITREQ(waitreq));

  // Accepted writes as the slave would see them at the next rising edge
  always @(negedge CLK) begin
    if (wr_i && !waitreq) acc_imm.push_back({addr_i, wd_i});
    if (wr_v && !waitreq) acc_vs.push_back({addr_v, wd_v});
  end

  function automatic logic [31:0] model_word(input logic [31:0] p, input bit inc, input int k);
    int c;
    if (!inc) return p;
    c = (int'(p[14:8]) + 2 * k) % 128;
    return (p & 32'h80FF_80FF) | (32'(c) << 8) | (32'((c + 1) % 128) << 24);
  endfunction

  function automatic int model_eff(input int base, input int count);
    if (base >= 600) return 0;
    return (count < 600 - base) ? count : 600 - base;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input bit use_vs, input int base, input int count,
                       input logic [31:0] pat, input bit inc);
    cmd_base    = 12'(base);
    cmd_count   = 11'(count);
    cmd_pattern = pat;
    cmd_inc     = inc;
    if (use_vs) begin
      acc_vs.delete();
      start_vs = 1'b1;
    end else begin
      acc_imm.delete();
      start_imm = 1'b1;
    end
    step();
    start_imm = 1'b0;
    start_vs  = 1'b0;
  endtask

  task automatic wait_done_imm(input int limit, input bit rand_wr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (done_i) begin
        ok = 1'b1;
        break;
      end
      waitreq = rand_wr ? ($urandom_range(0, 3) == 0) : 1'b0;
      step();
    end
    waitreq = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    #25;
    tests_run++;
    if ({busy_i, done_i, aborted_i, err_i, cs_i, wr_i, be_i, addr_i, wd_i} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_imm got=%h exp=0", {busy_i, done_i, aborted_i, err_i, cs_i, wr_i, be_i, addr_i, wd_i});
    end
    tests_run++;
    if ({busy_v, done_v, aborted_v, err_v, cs_v, wr_v, be_v, addr_v, wd_v} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_vs got=%h exp=0", {busy_v, done_v, aborted_v, err_v, cs_v, wr_v, be_v, addr_v, wd_v});
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    step();
  endtask

  task automatic test_const_fill();
    logic [8:0]  exp_ctl;
    logic [43:0] exp_aw;
    issue(1'b0, 0, 4, 32'h0041_0041, 1'b0);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      exp_ctl = {cyc <= 5, cyc == 5, cyc <= 4, cyc <= 4, (cyc <= 4) ? 4'hF : 4'h0, 1'b0};
      tests_run++;
      if ({busy_i, done_i, cs_i, wr_i, be_i, aborted_i} !== exp_ctl) begin
        tests_failed++;
        $display("[TB] FAIL const_ctl cyc=%0d got=%b exp=%b", cyc, {busy_i, done_i, cs_i, wr_i, be_i, aborted_i}, exp_ctl);
      end
      if (cyc <= 4) begin
        exp_aw = {12'(cyc - 1), 32'h0041_0041};
        tests_run++;
        if ({addr_i, wd_i} !== exp_aw) begin
          tests_failed++;
          $display("[TB] FAIL const_word cyc=%0d got=%h exp=%h", cyc, {addr_i, wd_i}, exp_aw);
        end
      end
      step();
    end
  endtask

  task automatic test_waitreq_hold();
    int exp_addr[7] = '{0, 1, 1, 1, 1, 2, 3};
    issue(1'b0, 0, 4, 32'h0041_0041, 1'b0);
    for (int cyc = 1; cyc <= 9; cyc++) begin
      waitreq = (cyc >= 2 && cyc <= 4);
      tests_run++;
      if ({wr_i, done_i, busy_i} !== {cyc <= 7, cyc == 8, cyc <= 8}) begin
        tests_failed++;
        $display("[TB] FAIL hold_ctl cyc=%0d got=%b exp=%b", cyc, {wr_i, done_i, busy_i}, {cyc <= 7, cyc == 8, cyc <= 8});
      end
      if (cyc <= 7) begin
        tests_run++;
        if ({addr_i, wd_i, be_i} !== {12'(exp_addr[cyc - 1]), 32'h0041_0041, 4'hF}) begin
          tests_failed++;
          $display("[TB] FAIL hold_word cyc=%0d got=%h exp_addr=%0d", cyc, {addr_i, wd_i, be_i}, exp_addr[cyc - 1]);
        end
      end
      step();
    end
    waitreq = 1'b0;
    tests_run++;
    if (acc_imm.size() != 4) begin
      tests_failed++;
      $display("[TB] FAIL hold_count got=%0d exp=4", acc_imm.size());
    end
  endtask

  task automatic test_inc_wrap();
    bit ok;
    issue(1'b0, 20, 2, 32'h807E_7E7E, 1'b1);
    wait_done_imm(20, 1'b0, ok);
    tests_run++;
    if (!ok || acc_imm.size() != 2) begin
      tests_failed++;
      $display("[TB] FAIL inc_count got=%0d exp=2 done=%0b", acc_imm.size(), ok);
    end else begin
      tests_run++;
      if (acc_imm[0] !== {12'd20, 32'hFF7E_7E7E}) begin
        tests_failed++;
        $display("[TB] FAIL inc_word0 got=%h exp=%h", acc_imm[0], {12'd20, 32'hFF7E_7E7E});
      end
      tests_run++;
      if (acc_imm[1] !== {12'd21, 32'h817E_007E}) begin
        tests_failed++;
        $display("[TB] FAIL inc_word1 got=%h exp=%h", acc_imm[1], {12'd21, 32'h817E_007E});
      end
    end
    step();
  endtask

  task automatic test_clamp_and_err();
    bit ok;
    issue(1'b0, 598, 10, 32'h1234_5678, 1'b0);
    wait_done_imm(30, 1'b0, ok);
    tests_run++;
    if (!ok || err_i || acc_imm.size() != 2 || acc_imm[0][43:32] != 12'd598 || acc_imm[1][43:32] != 12'd599) begin
      tests_failed++;
      $display("[TB] FAIL clamp got_n=%0d err=%b done=%0b exp_n=2 addrs 598,599", acc_imm.size(), err_i, ok);
    end
    step();
    issue(1'b0, 600, 5, 32'h1234_5678, 1'b0);
    tests_run++;
    if ({done_i, err_i, wr_i, aborted_i} !== 4'b1100) begin
      tests_failed++;
      $display("[TB] FAIL base_err got=%b exp=1100", {done_i, err_i, wr_i, aborted_i});
    end
    step();
    tests_run++;
    if ({done_i, err_i, busy_i} !== 3'b010 || acc_imm.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL err_hold got=%b n=%0d exp=010 n=0", {done_i, err_i, busy_i}, acc_imm.size());
    end
    issue(1'b0, 10, 0, 32'h1234_5678, 1'b0);
    tests_run++;
    if ({done_i, err_i, wr_i} !== 3'b100) begin
      tests_failed++;
      $display("[TB] FAIL zero_count got=%b exp=100", {done_i, err_i, wr_i});
    end
    step();
    tests_run++;
    if (acc_imm.size() != 0 || busy_i) begin
      tests_failed++;
      $display("[TB] FAIL zero_writes got_n=%0d busy=%b exp 0 0", acc_imm.size(), busy_i);
    end
  endtask

  task automatic test_vs_sync();
    bit ok;
    vs = 1'b1;
    step();
    step();
    issue(1'b1, 40, 3, 32'h0F20_0F20, 1'b0);
    for (int cyc = 1; cyc <= 4; cyc++) begin
      tests_run++;
      if ({wr_v, busy_v} !== 2'b01) begin
        tests_failed++;
        $display("[TB] FAIL vs_wait cyc=%0d got=%b exp=01", cyc, {wr_v, busy_v});
      end
      step();
    end
    vs = 1'b0;
    step();
    tests_run++;
    if ({wr_v, addr_v} !== {1'b1, 12'd40}) begin
      tests_failed++;
      $display("[TB] FAIL vs_first got=%h exp=%h", {wr_v, addr_v}, {1'b1, 12'd40});
    end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (done_v) ok = 1'b1;
      else step();
    end
    tests_run++;
    if (!ok || acc_vs.size() != 3 || aborted_v) begin
      tests_failed++;
      $display("[TB] FAIL vs_fill got_n=%0d done=%0b aborted=%b exp_n=3", acc_vs.size(), ok, aborted_v);
    end
    vs = 1'b1;
    step();
    step();
    issue(1'b1, 50, 5, 32'h0F20_0F20, 1'b0);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    tests_run++;
    if ({done_v, aborted_v, wr_v} !== 3'b110) begin
      tests_failed++;
      $display("[TB] FAIL vs_abort got=%b exp=110", {done_v, aborted_v, wr_v});
    end
    step();
    tests_run++;
    if (acc_vs.size() != 0 || busy_v) begin
      tests_failed++;
      $display("[TB] FAIL vs_abort_writes got_n=%0d busy=%b exp 0 0", acc_vs.size(), busy_v);
    end
  endtask

  task automatic test_abort_and_reset();
    issue(1'b0, 100, 8, 32'h0A41_0A41, 1'b0);
    step();
    step();
    waitreq = 1'b1;
    abort   = 1'b1;
    step();
    abort = 1'b0;
    tests_run++;
    if ({wr_i, addr_i} !== {1'b1, 12'd102}) begin
      tests_failed++;
      $display("[TB] FAIL abort_hold got=%h exp=%h", {wr_i, addr_i}, {1'b1, 12'd102});
    end
    step();
    waitreq = 1'b0;
    step();
    tests_run++;
    if ({done_i, aborted_i, wr_i} !== 3'b110 || acc_imm.size() != 3 || acc_imm[2][43:32] != 12'd102) begin
      tests_failed++;
      $display("[TB] FAIL abort_done got=%b n=%0d exp=110 n=3", {done_i, aborted_i, wr_i}, acc_imm.size());
    end
    step();
    issue(1'b0, 200, 8, 32'h0A41_0A41, 1'b0);
    step();
    RESET_N = 1'b0;
    #1;
    tests_run++;
    if ({wr_i, cs_i, busy_i} !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid got=%b exp=000", {wr_i, cs_i, busy_i});
    end
    @(negedge CLK);
    RESET_N = 1'b1;
    step();
  endtask

  task automatic test_random_fill(input int n);
    for (int t = 0; t < n; t++) begin
      int base, cnt, eff;
      logic [31:0] pat, exp_w;
      bit inc, ok;
      base = $urandom_range(0, 620);
      cnt  = $urandom_range(0, 24);
      if ($urandom_range(0, 3) == 0) begin
        base = $urandom_range(570, 610);
        cnt  = 2047;
      end
      pat = $urandom;
      inc = $urandom_range(0, 1);
      eff = model_eff(base, cnt);
      issue(1'b0, base, cnt, pat, inc);
      wait_done_imm(200, 1'b1, ok);
      tests_run++;
      if (!ok || err_i !== (base >= 600) || aborted_i !== 1'b0 || acc_imm.size() != eff) begin
        tests_failed++;
        $display("[TB] FAIL rand_cmd t=%0d base=%0d cnt=%0d got_n=%0d err=%b done=%0b exp_n=%0d",
                 t, base, cnt, acc_imm.size(), err_i, ok, eff);
      end else begin
        for (int k = 0; k < eff; k++) begin
          exp_w = model_word(pat, inc, k);
          tests_run++;
          if (acc_imm[k] !== {12'(base + k), exp_w}) begin
            tests_failed++;
            $display("[TB] FAIL rand_word t=%0d k=%0d got=%h exp=%h", t, k, acc_imm[k], {12'(base + k), exp_w});
          end
        end
      end
      step();
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    test_reset();
    test_const_fill();
    test_waitreq_hold();
    test_inc_wrap();
    test_clamp_and_err();
    test_vs_sync();
    test_abort_and_reset();
    test_random_fill(14);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
